// File: rtl/osd_pkg.sv
// Shared OSD text-buffer definitions: ASCII ranges, default geometry,
// field base-address computation and the hex reader state encoding.
package osd_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_UF = 8'h46;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LF = 8'h66;

    localparam int OSD_COLS   = 16;
    localparam int OSD_ADDR_W = 7;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_e;

    // Callers truncate to their buffer address width, which gives the wrap.
    function automatic logic [31:0] text_base_addr(input logic [3:0] line,
                                                   input logic [4:0] col,
                                                   input int         cols);
        return 32'(line) * 32'(cols) + 32'(col);
    endfunction

endpackage

// File: rtl/ascii_nibble_decode.sv
// Maps one ASCII character to a hex nibble; non-hex characters give 0
// and raise the invalid flag.
module ascii_nibble_decode
    import osd_pkg::*;
(
    input  logic [7:0] ch_i,
    output logic [3:0] nibble_o,
    output logic       invalid_o
);

    always_comb begin
        nibble_o  = 4'h0;
        invalid_o = 1'b1;
        if (ch_i >= ASCII_0 && ch_i <= ASCII_9) begin
            nibble_o  = ch_i[3:0];
            invalid_o = 1'b0;
        end else if ((ch_i >= ASCII_UA && ch_i <= ASCII_UF) ||
                     (ch_i >= ASCII_LA && ch_i <= ASCII_LF)) begin
            // Both letter ranges start at low nibble 1, so 'A'/'a' -> 1 + 9.
            nibble_o  = ch_i[3:0] + 4'd9;
            invalid_o = 1'b0;
        end
    end

endmodule

// File: rtl/ascii_hex_reader.sv
// Reads a NUM_DIGITS-character hex field from the OSD text buffer over a
// shared request/grant read port and decodes it into a binary value.
module ascii_hex_reader
    import osd_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int COLS       = OSD_COLS,
    parameter int ADDR_W     = OSD_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [3:0]              linea,
    input  logic [4:0]              columna,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    err,
    output logic                    rd_req,
    input  logic                    rd_gnt,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [7:0]              rd_data
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    rd_state_e          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               cap_q;
    logic [VAL_W-1:0]   acc_q, acc_d;
    logic               acc_err_q, acc_err_d;
    logic [VAL_W-1:0]   value_q;
    logic               err_q;
    logic [ADDR_W-1:0]  base;
    logic [3:0]         nib;
    logic               nib_bad;
    logic               accept;
    logic               issue_fire;
    logic               last_issue;

    ascii_nibble_decode u_decode (
        .ch_i      (rd_data),
        .nibble_o  (nib),
        .invalid_o (nib_bad)
    );

    assign base       = ADDR_W'(text_base_addr(linea, columna, COLS));
    assign accept     = (state_q == RD_IDLE) && start;
    assign issue_fire = (state_q == RD_ISSUE) && rd_gnt;
    assign last_issue = (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE:  if (start) state_d = RD_ISSUE;
            RD_ISSUE: if (rd_gnt && last_issue) state_d = RD_DRAIN;
            RD_DRAIN: state_d = RD_DONE;
            RD_DONE:  state_d = RD_IDLE;
            default:  state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != RD_IDLE);
        done   = (state_q == RD_DONE);
        rd_req = (state_q == RD_ISSUE);
    end

    // The address register doubles as the port output, so it naturally holds
    // the last issued address while the port is not requested.
    always_comb begin
        idx_d  = idx_q;
        addr_d = addr_q;
        if (accept) begin
            idx_d  = '0;
            addr_d = base;
        end else if (issue_fire && !last_issue) begin
            idx_d  = idx_q + 1'b1;
            addr_d = addr_q + 1'b1;
        end
    end

    always_comb begin
        acc_d     = acc_q;
        acc_err_d = acc_err_q;
        if (accept) begin
            acc_d     = '0;
            acc_err_d = 1'b0;
        end else if (cap_q) begin
            acc_d     = (acc_q << 4) | VAL_W'(nib);
            acc_err_d = acc_err_q | nib_bad;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            addr_q  <= '0;
            cap_q   <= 1'b0;
            value_q <= '0;
            err_q   <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            addr_q <= addr_d;
            cap_q  <= issue_fire;
            // The final capture lands on the same edge that enters DONE.
            if (state_q == RD_DRAIN) begin
                value_q <= acc_d;
                err_q   <= acc_err_d;
            end
        end
    end

    // Accumulators are always cleared by an accepted start before use.
    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        acc_err_q <= acc_err_d;
    end

    assign value   = value_q;
    assign err     = err_q;
    assign rd_addr = addr_q;

endmodule

// File: doc/ascii_hex_reader.md
# ascii_hex_reader

Reads a fixed-width hexadecimal field back out of the OSD text buffer and decodes the ASCII digits into a binary value. It is the decoder counterpart of `ascii_hex_writer`: same line/column addressing, same digit order (most significant digit at the lowest address). It shares the text buffer read port with `text_renderer_buffered` through a request/grant pair. It is used for OSD self-check and for scrubbing values the debugger has already displayed.

## Interface
Parameters:
- `NUM_DIGITS`, 2: digits per field; value width is 4*NUM_DIGITS.
- `COLS`, 16: characters per text line; must match `ascii_hex_writer`.
- `ADDR_W`, 7: text buffer address width.

Ports:
- `clk` in 1: system clock; one clock domain only.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request to read a field; accepted only in IDLE.
- `linea` in 4: line of the field, sampled with `start`.
- `columna` in 5: column of the first (most significant) digit, sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done` out 1: one-cycle pulse; `value` and `err` are valid from this cycle on.
- `value` out 4*NUM_DIGITS: decoded field, held until the next `done`.
- `err` out 1: at least one digit was not a valid hex character; held until the next `done`.
- `rd_req` out 1: requests the text buffer read port.
- `rd_gnt` in 1: read port granted this cycle.
- `rd_addr` out ADDR_W: text buffer read address.
- `rd_data` in 8: text buffer read data; synchronous RAM, valid one cycle after the address is issued.

## Operation
- Base address = (linea*COLS + columna) mod 2^ADDR_W. Digit i is at address (base + i) mod 2^ADDR_W, so addresses wrap at the top of the buffer.
- States:
  - IDLE: waits for `start`. On `start`, latches the base address, clears the digit index and the error accumulator, and moves to ISSUE.
  - ISSUE: drives `rd_req`=1 and `rd_addr`=base+index. Each cycle with `rd_gnt`=1, the index increments and a capture is scheduled for the next cycle. When the last digit is issued, moves to DRAIN.
  - DRAIN: captures the last digit, then moves to DONE.
  - DONE: raises `done` for one cycle and returns to IDLE.
- Capture happens in every cycle that follows an issued read, regardless of state or grant. The accumulator shifts left 4 bits and ORs in the decoded nibble.
- Decode rules:
  - '0'-'9' (0x30-0x39) give 0-9.
  - 'A'-'F' (0x41-0x46) and 'a'-'f' (0x61-0x66) give 10-15.
  - Any other byte gives nibble 0 and sets the error accumulator.
- `value` and `err` load from the accumulators on entry to DONE only. They keep the previous result while busy.
- `start` in any state other than IDLE is ignored, with no queuing. `start` in the DONE cycle is also ignored.
- `rd_req` is 0 outside ISSUE. `rd_addr` holds its last value when not requesting.
- Reset values: IDLE, `busy`=0, `done`=0, `value`=0, `err`=0, `rd_req`=0, `rd_addr`=0.
- Reset mid-operation aborts the read with no `done`. After reset release the block is in IDLE and accepts `start` on the next cycle.

## Timing
- `start` sampled in cycle 0. First `rd_req` and `busy` appear in cycle 1.
- With `rd_gnt` held high, reads issue in cycles 1..NUM_DIGITS, and `done` pulses in cycle NUM_DIGITS+2 (cycle 4 for the default).
- Each cycle of `rd_gnt`=0 in ISSUE delays `done` by exactly one cycle. No read is lost or repeated.
- Back-to-back throughput: a new `start` is accepted in the cycle after `done`, giving one field per NUM_DIGITS+3 cycles.
- No combinational path from `rd_gnt` or `rd_data` to any output.

## Structure
- Shared package `osd_pkg` holds:
  - ASCII range constants ('0', '9', 'A', 'F', 'a', 'f').
  - Default `COLS`/`ADDR_W`.
  - The base-address function, also used by `ascii_hex_writer`.
  - The state enum (IDLE, ISSUE, DRAIN, DONE).
- One combinational sub-module, `ascii_nibble_decode`: 8-bit char in; 4-bit nibble and invalid flag out.

## Test plan
- Buffer holds "3F" at line 1, col 8 (COLS=16, addr 24/25); `start`; `rd_gnt`=1 -> `rd_addr` 24 then 25, `done` at cycle 4, `value`=0x3F, `err`=0.
- Lowercase "a5" at line 2, col 8 -> `value`=0xA5, `err`=0.
- "G1" -> `value`=0x01, `err`=1. A following read of "7E" -> `err` returns to 0, `value`=0x7E.
- `rd_gnt` low for 3 cycles after the first issue -> `done` at cycle 7, correct `value`, each address issued exactly once.
- Line 7, col 15 (addr 127) holding "C", addr 0 holding "4" -> `rd_addr` 127 then 0, `value`=0xC4.
- `start` pulses in cycles 2 and 4 are ignored, giving a single `done`. A separate run asserts `reset_n` low in cycle 2 -> no `done`, all outputs at reset values, and a new `start` after release completes normally.
